// File: rtl/bcd_serial_subtractor.sv
// Multi-digit packed-BCD subtractor, one digit per clock, LSD first.
// Negative results come back in ten's complement with Bout set. Needs DIGITS >= 2.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Bin,
  output logic [4*DIGITS-1:0] D,
  output logic                Bout,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q, b_q;
  logic          brw;
  logic          bad;
  logic [4:0]    t;
  logic [3:0]    digit;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  // Operands shift right, so the current digit is always in the low nibble.
  assign t     = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'd0, brw};
  assign digit = t[4] ? t[3:0] + 4'd10 : t[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      brw   <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q  <= A;
            b_q  <= B;
            brw  <= Bin;
            cnt  <= '0;
            D    <= '0;
            Bout <= 1'b0;
            if (bad) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // Digits enter at the top; after DIGITS shifts digit 0 sits in D[3:0].
          D   <= {digit, D[W-1:4]};
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          brw <= t[4];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            Bout  <= t[4];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Error path arrives with done low and raises it one cycle later.
          if (done) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (DIGITS=4).
module tb_bcd_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst, start, Bin;
  logic [15:0] A, B;
  logic [15:0] D;
  logic        Bout, busy, done, err;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  logic        busy0;
  logic        seen;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .D(D), .Bout(Bout), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lat = number of cycles after the start edge until done is seen (0 = cycle right after it)
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic bin,
                     output int l, output logic b0);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b0 = busy;
    l = 0;
    while (!done && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_D", D, 16'h0000);
    chk("rst_ctl", {Bout, busy, done, err}, 4'b0000);
    rst = 1'b0;

    // 0042 - 0017
    run(16'h0042, 16'h0017, 1'b0, lat, busy0);
    chk("t1_busy", busy0, 1'b1);
    chk("t1_lat", lat, 4);
    chk("t1_D", D, 16'h0025);
    chk("t1_flags", {Bout, err, busy}, 3'b000);
    @(negedge clk);
    chk("t1_done_pulse", done, 1'b0);

    // 0000 - 0001 wraps to ten's complement
    run(16'h0000, 16'h0001, 1'b0, lat, busy0);
    chk("t2_lat", lat, 4);
    chk("t2_D", D, 16'h9999);
    chk("t2_Bout", Bout, 1'b1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("t2_hold_D", D, 16'h9999);
    chk("t2_hold_Bout", Bout, 1'b1);
    chk("t2_no_done", seen, 1'b0);

    // borrow ripples across every digit
    run(16'h5000, 16'h4999, 1'b1, lat, busy0);
    chk("t3_D", D, 16'h0000);
    chk("t3_Bout", Bout, 1'b0);

    // A==B with borrow-in
    run(16'h1234, 16'h1234, 1'b1, lat, busy0);
    chk("t3b_D", D, 16'h9999);
    chk("t3b_Bout", Bout, 1'b1);

    // invalid digit in A
    run(16'h00A3, 16'h0001, 1'b0, lat, busy0);
    chk("t4_lat", lat, 1);
    chk("t4_err", err, 1'b1);
    chk("t4_D", D, 16'h0000);
    chk("t4_Bout", Bout, 1'b0);
    run(16'h0009, 16'h0009, 1'b0, lat, busy0);
    chk("t4b_err", err, 1'b0);
    chk("t4b_D", D, 16'h0000);
    chk("t4b_lat", lat, 4);

    // second start during CALC is ignored, operands may change
    @(negedge clk);
    A = 16'h1234; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t5_lat", lat, 4);
    chk("t5_D", D, 16'h1233);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("t5_no_reop", seen, 1'b0);

    // reset mid-operation aborts with no done pulse
    @(negedge clk);
    A = 16'h1234; B = 16'h0567; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_D", D, 16'h0000);
    chk("t6_rst_ctl", {Bout, busy, done, err}, 4'b0000);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("t6_no_done", seen, 1'b0);
    run(16'h1234, 16'h0567, 1'b0, lat, busy0);
    chk("t6_D", D, 16'h0667);
    chk("t6_Bout", Bout, 1'b0);
    chk("t6_lat", lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
